// File: rtl/frame_tx_reader_pkg.sv
// Shared types and constants for the frame FIFO transmit reader.
// State encoding, framing bytes and CRC-32 constants.
package frame_tx_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DRAIN
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [10:0] LEN_MAX       = 11'h7FF;

  function automatic logic [10:0] len_sat_inc(
    input logic [10:0] l
  );
    return (l == LEN_MAX) ? l : l + 11'd1;
  endfunction

endpackage

// File: rtl/frame_tx_reader_crc32_d8.sv
// Combinational CRC-32 (reflected, poly 0xEDB88320) update for one byte.
// Ports: crc (current), data (byte, LSB first), crc_next (updated).
module crc32_d8
  import frame_tx_reader_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/frame_tx_reader.sv
// Frame FIFO reader: emits preamble, SFD, payload, pad, FCS, then an IFG.
// Ports: clk/arst_n, fifo_* read side, tx_ready/tx_data/tx_en, busy, underrun.
module frame_tx_reader
  import frame_tx_reader_pkg::*;
#(
  parameter int PRE_LEN    = 7,
  parameter int MIN_LEN    = 60,
  parameter int IFG_LEN    = 12,
  parameter int APPEND_FCS = 1
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [7:0] fifo_do,
  input  logic       fifo_eod,
  input  logic       fifo_empty,
  input  logic       fifo_frame,
  output logic       fifo_re,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       busy,
  output logic       underrun
);

  localparam logic [3:0]  PRE_LAST = 4'(PRE_LEN);
  localparam logic [3:0]  IFG_LAST = 4'(IFG_LEN - 1);
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam state_t      TAIL_ST  =
    (APPEND_FCS != 0) ? ST_FCS : ST_IFG;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [10:0] len;
  logic [31:0] crc;

  logic [10:0] len_new;
  logic [31:0] crc_seed;
  logic [31:0] crc_nx;
  logic [7:0]  crc_din;
  logic [7:0]  fcs_byte;
  state_t      end_st;

  // SFD exit restarts the CRC and length; PAD feeds zeros.
  always_comb begin
    len_new  = (state == ST_SFD) ? 11'd1 : len_sat_inc(len);
    crc_seed = (state == ST_SFD) ? CRC32_INIT : crc;
    crc_din  = (state == ST_PAD) ? 8'h00 : fifo_do;
    end_st   = (len_new < MIN_L) ? ST_PAD : TAIL_ST;
    fcs_byte = 8'h00;
    unique case (cnt[1:0])
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      2'd3: fcs_byte = ~crc[31:24];
    endcase
  end

  crc32_d8 u_crc (
    .crc      (crc_seed),
    .data     (crc_din),
    .crc_next (crc_nx)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (tx_ready && fifo_frame) state_nx = ST_PRE;
      ST_PRE:
        if (tx_ready && cnt == PRE_LAST) state_nx = ST_SFD;
      ST_SFD, ST_DATA:
        if (tx_ready) begin
          if (fifo_empty)    state_nx = ST_DRAIN;
          else if (fifo_eod) state_nx = end_st;
          else               state_nx = ST_DATA;
        end
      ST_PAD:
        if (tx_ready) state_nx = end_st;
      ST_FCS:
        if (tx_ready && cnt == 4'd3) state_nx = ST_IFG;
      ST_IFG:
        if (tx_ready && cnt == IFG_LAST) state_nx = ST_IDLE;
      ST_DRAIN:
        if (!fifo_empty && fifo_eod) state_nx = ST_IFG;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_re = 1'b0;
    unique case (state)
      ST_SFD, ST_DATA: fifo_re = tx_ready & ~fifo_empty;
      ST_DRAIN:        fifo_re = ~fifo_empty;
      default:         fifo_re = 1'b0;
    endcase
    busy = (state != ST_IDLE);
  end

  // Output bytes load only on tx_ready strobes; cnt is reused as
  // preamble, FCS byte and IFG strobe index.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_data  <= 8'h00;
      tx_en    <= 1'b0;
      underrun <= 1'b0;
      cnt      <= 4'd0;
      len      <= 11'd0;
      crc      <= 32'd0;
    end else begin
      underrun <= 1'b0;
      unique case (state)
        ST_IDLE:
          if (tx_ready && fifo_frame) begin
            tx_data <= PREAMBLE_BYTE;
            tx_en   <= 1'b1;
            cnt     <= 4'd1;
          end
        ST_PRE:
          if (tx_ready) begin
            if (cnt == PRE_LAST) begin
              tx_data <= SFD_BYTE;
              cnt     <= 4'd0;
            end else begin
              tx_data <= PREAMBLE_BYTE;
              cnt     <= cnt + 4'd1;
            end
          end
        ST_SFD, ST_DATA:
          if (tx_ready) begin
            cnt <= 4'd0;
            if (fifo_empty) begin
              underrun <= 1'b1;
              tx_en    <= 1'b0;
              tx_data  <= 8'h00;
            end else begin
              tx_data <= fifo_do;
              crc     <= crc_nx;
              len     <= len_new;
            end
          end
        ST_PAD:
          if (tx_ready) begin
            tx_data <= 8'h00;
            crc     <= crc_nx;
            len     <= len_new;
          end
        ST_FCS:
          if (tx_ready) begin
            tx_data <= fcs_byte;
            cnt     <= (cnt == 4'd3) ? 4'd0 : cnt + 4'd1;
          end
        ST_IFG:
          if (tx_ready) begin
            tx_data <= 8'h00;
            tx_en   <= 1'b0;
            cnt     <= cnt + 4'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_reader.sv
// Scoreboard bench for frame_tx_reader with a FIFO model and
// a byte-stream reference model built from framing rules.
module tb_frame_tx_reader;

  localparam int PRE_LEN = 7;
  localparam int MIN_LEN = 60;
  localparam int IFG_LEN = 12;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [7:0] fifo_do;
  logic       fifo_eod;
  logic       fifo_empty;
  logic       fifo_frame;
  logic       fifo_re;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       busy;
  logic       underrun;

  always #5 clk = ~clk;

  frame_tx_reader #(
    .PRE_LEN    (PRE_LEN),
    .MIN_LEN    (MIN_LEN),
    .IFG_LEN    (IFG_LEN),
    .APPEND_FCS (1)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .fifo_do    (fifo_do),
    .fifo_eod   (fifo_eod),
    .fifo_empty (fifo_empty),
    .fifo_frame (fifo_frame),
    .fifo_re    (fifo_re),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .busy       (busy),
    .underrun   (underrun)
  );

  typedef struct {
    logic       en;
    logic [7:0] d;
    int         gchk;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       eod;
  } fb_t;

  typedef logic [7:0] bq_t[$];

  exp_t exp_q[$];
  fb_t  fq[$];

  int checks = 0;
  int errors = 0;
  int nframes = 0;
  int popped = 0;
  int arm_force = -1;
  int force_cnt = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int exp_und = 0;
  int obs_und = 0;

  task automatic chk(input bit ok, input string name,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Ethernet FCS: bitwise reflected CRC-32 over the whole message.
  function automatic logic [31:0] fcs_of(input bq_t m);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (m[i]) begin
      b = m[i];
      for (int k = 0; k < 8; k++) begin
        fb = b[k] ^ c[0];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic bq_t rnd_pl(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  // Queue payload in the FIFO model and the expected tx stream.
  task automatic push_frame(input bq_t pl, input int und_at,
                            input int gchk);
    bq_t         body;
    logic [31:0] f;
    body = pl;
    foreach (pl[i])
      fq.push_back('{pl[i], (i == pl.size() - 1)});
    nframes++;
    for (int i = 0; i < PRE_LEN; i++)
      exp_q.push_back('{1'b1, 8'h55, (i == 0) ? gchk : 0});
    exp_q.push_back('{1'b1, 8'hD5, 0});
    if (und_at > 0) begin
      for (int i = 0; i < und_at; i++)
        exp_q.push_back('{1'b1, pl[i], 0});
      exp_und++;
    end else begin
      while (body.size() < MIN_LEN) body.push_back(8'h00);
      foreach (body[i]) exp_q.push_back('{1'b1, body[i], 0});
      f = fcs_of(body);
      for (int k = 0; k < 4; k++)
        exp_q.push_back('{1'b1, f[8*k +: 8], 0});
    end
    exp_q.push_back('{1'b0, 8'h00, 0});
  endtask

  task automatic tick();
    fb_t h;
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = cyc[0];
      default: tx_ready = ($urandom_range(0, 9) < 7);
    endcase
    if (force_cnt > 0) force_cnt--;
    if (fq.size() == 0 || force_cnt > 0) begin
      fifo_empty = 1'b1;
      fifo_do    = 8'h00;
      fifo_eod   = 1'b0;
    end else begin
      fifo_empty = 1'b0;
      fifo_do    = fq[0].d;
      fifo_eod   = fq[0].eod;
    end
    fifo_frame = (nframes > 0);
    #1;
    if (force_cnt > 0 && underrun) force_cnt = 0;
    if (fifo_re && !fifo_empty) begin
      h = fq.pop_front();
      popped++;
      if (h.eod) nframes--;
      if (arm_force > 0 && popped == arm_force) begin
        force_cnt = 50;
        arm_force = -1;
      end
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() > 0 || fq.size() > 0 || busy)
           && n < budget) begin
      tick();
      n++;
    end
    chk(n < budget, name, n, budget);
  endtask

  // Monitor: checks every consumed byte against the scoreboard.
  logic       mon_active = 1'b0;
  logic       gap_valid = 1'b0;
  int         gap = 0;
  logic       prev_valid = 1'b0;
  logic       prev_rdy = 1'b0;
  logic       prev_und = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!arst_n) begin
      mon_active = 1'b0;
      gap_valid  = 1'b0;
      gap        = 0;
      prev_valid = 1'b0;
      prev_und   = 1'b0;
    end else begin
      if (fifo_re) chk(!fifo_empty, "re_when_empty", 1, 0);
      if (prev_valid && tx_data !== prev_data)
        chk(prev_rdy, "data_change_no_strobe",
            int'(tx_data), int'(prev_data));
      if (underrun) begin
        obs_und++;
        chk(!prev_und, "underrun_pulse_width", 2, 1);
      end
      prev_valid = 1'b1;
      prev_rdy   = tx_ready;
      prev_und   = underrun;
      prev_data  = tx_data;
      if (tx_ready) begin
        if (!mon_active) begin
          if (tx_en) begin
            if (exp_q.size() == 0) begin
              chk(1'b0, "unexpected_tx_byte", int'(tx_data), 0);
            end else begin
              e = exp_q.pop_front();
              if (gap_valid && e.gchk == 2)
                chk(gap == IFG_LEN, "ifg_exact", gap, IFG_LEN);
              else if (gap_valid && e.gchk == 1)
                chk(gap >= IFG_LEN, "ifg_min", gap, IFG_LEN);
              chk({tx_en, tx_data} === {e.en, e.d}, "frame_start",
                  int'({tx_en, tx_data}), int'({e.en, e.d}));
              mon_active = 1'b1;
            end
          end else begin
            gap++;
          end
        end else if (exp_q.size() == 0) begin
          chk(1'b0, "stream_overrun", int'({tx_en, tx_data}), 0);
          mon_active = 1'b0;
        end else begin
          e = exp_q.pop_front();
          chk({tx_en, tx_data} === {e.en, e.d}, "tx_byte",
              int'({tx_en, tx_data}), int'({e.en, e.d}));
          if (!e.en) begin
            mon_active = 1'b0;
            gap        = 1;
            gap_valid  = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t pl;
    int  n;
    arst_n     = 1'b0;
    tx_ready   = 1'b0;
    fifo_do    = 8'h00;
    fifo_eod   = 1'b0;
    fifo_empty = 1'b1;
    fifo_frame = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk(tx_en == 1'b0, "rst_tx_en", int'(tx_en), 0);
    chk(tx_data == 8'h00, "rst_tx_data", int'(tx_data), 0);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
    chk(fifo_re == 1'b0, "rst_fifo_re", int'(fifo_re), 0);
    chk(underrun == 1'b0, "rst_underrun", int'(underrun), 0);
    @(negedge clk);
    arst_n = 1'b1;

    // "123456789" payload, padded to the minimum length.
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    rdy_mode = 0;
    push_frame(pl, -1, 1);
    wait_done(2000, "done_crc_frame");

    // 10-byte payload -> 50 pad bytes.
    push_frame(rnd_pl(10), -1, 1);
    wait_done(2000, "done_pad_frame");

    // Two 64-byte frames queued back to back.
    push_frame(rnd_pl(64), -1, 1);
    push_frame(rnd_pl(64), -1, 2);
    wait_done(2000, "done_b2b");

    // Throttled strobes on every second cycle.
    rdy_mode = 1;
    push_frame(rnd_pl(70), -1, 1);
    push_frame(rnd_pl(5), -1, 1);
    wait_done(4000, "done_throttle");

    // Random strobes, random lengths including saturating pad edge.
    rdy_mode = 2;
    push_frame(rnd_pl(59), -1, 1);
    push_frame(rnd_pl(60), -1, 1);
    push_frame(rnd_pl(61), -1, 1);
    for (int f = 0; f < 4; f++)
      push_frame(rnd_pl($urandom_range(1, 100)), -1, 1);
    wait_done(8000, "done_random");

    // Underrun at payload byte 5 with full-rate strobes.
    rdy_mode  = 0;
    popped    = 0;
    arm_force = 4;
    push_frame(rnd_pl(20), 4, 1);
    wait_done(2000, "done_underrun");

    // Underrun at a random point with random strobes.
    rdy_mode  = 2;
    popped    = 0;
    n         = $urandom_range(1, 10);
    arm_force = n;
    push_frame(rnd_pl(30), n, 1);
    wait_done(4000, "done_underrun_rnd");

    // Reset mid-payload, then a clean frame.
    rdy_mode = 0;
    popped   = 0;
    push_frame(rnd_pl(40), -1, 1);
    n = 0;
    while (popped < 10 && n < 300) begin
      tick();
      n++;
    end
    chk(popped >= 10, "reach_data", popped, 10);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk(tx_en == 1'b0, "arst_tx_en", int'(tx_en), 0);
    chk(tx_data == 8'h00, "arst_tx_data", int'(tx_data), 0);
    chk(fifo_re == 1'b0, "arst_fifo_re", int'(fifo_re), 0);
    chk(busy == 1'b0, "arst_busy", int'(busy), 0);
    fq.delete();
    exp_q.delete();
    nframes = 0;
    repeat (2) tick();
    @(negedge clk);
    arst_n = 1'b1;
    push_frame(rnd_pl(65), -1, 0);
    wait_done(2000, "done_after_reset");

    chk(obs_und == exp_und, "underrun_count", obs_und, exp_und);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
